// File: rtl/const_arith_pkg.sv
// Shared definitions for the constant-arithmetic blocks (constant divider and
// its inverse, the constant multiplier).
//   state_t : FSM encoding shared by the sequential constant-arithmetic blocks
//   res_w   : result width of quo*K + rem (no overflow possible)
//   cnt_w   : iteration counter width for a given constant width (minimum 1)
package const_arith_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  function automatic int res_w(input int quo_w, input int const_w);
    return quo_w + const_w;
  endfunction

  function automatic int cnt_w(input int const_w);
    return (const_w > 1) ? $clog2(const_w) : 1;
  endfunction

  // Default configuration (K = 38): constant width and counter width.
  localparam int DEF_MUL     = 38;
  localparam int DEF_CONST_W = $clog2(DEF_MUL + 1);
  localparam int CNT_W       = cnt_w(DEF_CONST_W);

endpackage

// File: rtl/constant_mul_seq.sv
// Sequential shift-add multiplier that rebuilds a dividend from a
// quotient/remainder pair: o_res = i_quo * K + i_rem. K is either the MUL
// parameter (MUL_MODE=0) or sampled from i_mul_const at accept (MUL_MODE=1).
// o_rem_err flags i_rem >= K. Latency is fixed at CONST_W BUSY cycles.
// Ports:
//   i_clk, i_rst       clock (rising edge), async active-high reset
//   i_vld / o_rdy      input pair handshake (o_rdy high only in IDLE)
//   i_quo, i_rem       operands
//   i_mul_const        runtime K (MUL_MODE=1 only)
//   o_vld / i_rdy      result handshake
//   o_res, o_rem_err   result and out-of-range remainder flag
//
// state | meaning
// IDLE  | waiting for an input pair, o_rdy=1
// BUSY  | one shift-add iteration per cycle, CONST_W cycles
// DONE  | result presented on o_vld until i_rdy
module constant_mul_seq
  import const_arith_pkg::*;
#(
  parameter int MUL_MODE = 0,
  parameter int MUL      = 38,
  parameter int QUO_W    = 16,
  parameter int CONST_W  = $clog2(MUL + 1),
  parameter int RES_W    = res_w(QUO_W, CONST_W)
) (
  input  logic               i_clk,
  input  logic               i_rst,
  input  logic               i_vld,
  output logic               o_rdy,
  input  logic [QUO_W-1:0]   i_quo,
  input  logic [CONST_W-1:0] i_rem,
  input  logic [CONST_W-1:0] i_mul_const,
  output logic               o_vld,
  input  logic               i_rdy,
  output logic [RES_W-1:0]   o_res,
  output logic               o_rem_err
);

  localparam int LCNT_W = cnt_w(CONST_W);
  localparam logic [CONST_W-1:0] K_PARAM = CONST_W'(MUL);
  localparam logic [LCNT_W-1:0]  LAST    = LCNT_W'(CONST_W - 1);

  state_t state, state_nxt;

  logic [RES_W-1:0]   acc;
  logic [RES_W-1:0]   mcand;
  logic [CONST_W-1:0] mplier;
  logic [LCNT_W-1:0]  cnt;
  logic               err;

  logic [CONST_W-1:0] k_sel;
  logic               accept;
  logic               last_iter;

  assign k_sel     = (MUL_MODE == 1) ? i_mul_const : K_PARAM;
  assign accept    = i_vld & o_rdy;
  assign last_iter = (cnt == LAST);

  // State register
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) state <= IDLE;
    else       state <= state_nxt;
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept) state_nxt = BUSY;
      BUSY:    if (last_iter) state_nxt = DONE;
      DONE:    if (o_vld && i_rdy) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Output decode
  always_comb begin
    o_rdy = (state == IDLE);
    o_vld = (state == DONE);
  end

  // Shift-add datapath. acc starts at the remainder so the final add of i_rem
  // is folded into the load; RES_W is wide enough that no carry is lost.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      acc    <= '0;
      mcand  <= '0;
      mplier <= '0;
      cnt    <= '0;
      err    <= 1'b0;
    end else if (accept) begin
      acc    <= RES_W'(i_rem);
      mcand  <= RES_W'(i_quo);
      mplier <= k_sel;
      err    <= (i_rem >= k_sel);
      cnt    <= '0;
    end else if (state == BUSY) begin
      if (mplier[0]) acc <= acc + mcand;
      mcand  <= mcand << 1;
      mplier <= mplier >> 1;
      cnt    <= cnt + 1'b1;
    end
  end

  assign o_res     = acc;
  assign o_rem_err = err;

endmodule

// File: tb/tb_constant_mul_seq.sv
module tb_constant_mul_seq;

  localparam int QW = 16;
  localparam int CW = 6;
  localparam int RW = 22;
  localparam int KP = 38;

  logic          clk = 1'b0;
  logic          rst;
  logic          vld0, vld1;
  logic          ordy0, ordy1;
  logic [QW-1:0] quo;
  logic [CW-1:0] rem;
  logic [CW-1:0] mul_const;
  logic          ovld0, ovld1;
  logic          irdy;
  logic [RW-1:0] res0, res1;
  logic          err0, err1;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  constant_mul_seq #(.MUL_MODE(0), .MUL(KP), .QUO_W(QW)) dut0 (
    .i_clk(clk), .i_rst(rst), .i_vld(vld0), .o_rdy(ordy0),
    .i_quo(quo), .i_rem(rem), .i_mul_const(mul_const),
    .o_vld(ovld0), .i_rdy(irdy), .o_res(res0), .o_rem_err(err0)
  );

  constant_mul_seq #(.MUL_MODE(1), .MUL(KP), .QUO_W(QW)) dut1 (
    .i_clk(clk), .i_rst(rst), .i_vld(vld1), .o_rdy(ordy1),
    .i_quo(quo), .i_rem(rem), .i_mul_const(mul_const),
    .o_vld(ovld1), .i_rdy(irdy), .o_res(res1), .o_rem_err(err1)
  );

  function automatic logic f_vld(input int sel);
    return (sel == 0) ? ovld0 : ovld1;
  endfunction
  function automatic logic f_rdy(input int sel);
    return (sel == 0) ? ordy0 : ordy1;
  endfunction
  function automatic logic [RW-1:0] f_res(input int sel);
    return (sel == 0) ? res0 : res1;
  endfunction
  function automatic logic f_err(input int sel);
    return (sel == 0) ? err0 : err1;
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // One complete transaction. kin drives i_mul_const, kexp is the K the model
  // uses. hold = cycles of i_rdy=0 in DONE. While the block is busy, the
  // inputs are scrambled and i_vld is held high to prove they are ignored.
  task automatic do_op(input int sel, input int q, input int r, input int kin,
                       input int kexp, input int hold);
    logic [63:0] exp_res;
    logic        exp_err;
    int          n;
    exp_res = 64'(q) * 64'(kexp) + 64'(r);
    exp_err = (r >= kexp);
    n = 0;
    while (!f_rdy(sel) && n < 50) begin step(); n++; end
    chk("rdy_before_accept", f_rdy(sel), 1);
    quo = QW'(q); rem = CW'(r); mul_const = CW'(kin);
    irdy = (hold == 0);
    if (sel == 0) vld0 = 1'b1; else vld1 = 1'b1;
    step();
    quo = QW'($urandom); rem = CW'($urandom); mul_const = CW'($urandom);
    n = 1;
    while (!f_vld(sel) && n < 50) begin
      chk("rdy_low_busy", f_rdy(sel), 0);
      step(); n++;
    end
    if (sel == 0) vld0 = 1'b0; else vld1 = 1'b0;
    chk("latency", n, CW + 1);
    chk("res", f_res(sel), exp_res);
    chk("rem_err", f_err(sel), exp_err);
    chk("rdy_low_done", f_rdy(sel), 0);
    for (int i = 0; i < hold; i++) begin
      step();
      chk("hold_vld", f_vld(sel), 1);
      chk("hold_res", f_res(sel), exp_res);
      chk("hold_err", f_err(sel), exp_err);
      chk("hold_rdy", f_rdy(sel), 0);
    end
    irdy = 1'b1;
    step();
    chk("post_hs_vld", f_vld(sel), 0);
    chk("post_hs_rdy", f_rdy(sel), 1);
    chk("post_hs_res_kept", f_res(sel), exp_res);
  endtask

  initial begin
    int q, r, k;
    rst = 1'b1; vld0 = 1'b0; vld1 = 1'b0; irdy = 1'b1;
    quo = '0; rem = '0; mul_const = '0;
    #1;
    chk("rst_vld", ovld0, 0);
    chk("rst_res", res0, 0);
    chk("rst_err", err0, 0);
    chk("rst_rdy", ordy0, 1);
    step(); step();
    rst = 1'b0;
    step();

    // Fixed-K directed cases
    do_op(0, 1000, 37, 0, KP, 0);
    do_op(0, 65535, 37, 5, KP, 0);
    do_op(0, 0, 0, 0, KP, 0);
    do_op(0, 10, 38, 0, KP, 0);
    do_op(0, 10, 63, 0, KP, 0);
    do_op(0, 1234, 5, 0, KP, 5);

    // Runtime-K directed cases
    do_op(1, 5, 3, 0, 0, 0);
    do_op(1, 1023, 62, 63, 63, 0);
    do_op(1, 65535, 63, 63, 63, 2);

    // Reset in the middle of an operation
    quo = 16'd500; rem = 6'd7; irdy = 1'b1; vld0 = 1'b1;
    step();
    vld0 = 1'b0;
    step(); step();
    rst = 1'b1;
    #1;
    chk("midrst_vld", ovld0, 0);
    chk("midrst_res", res0, 0);
    chk("midrst_err", err0, 0);
    chk("midrst_rdy", ordy0, 1);
    step();
    rst = 1'b0;
    step();
    do_op(0, 7, 1, 0, KP, 0);

    // Randomized operands against the arithmetic model
    for (int i = 0; i < 20; i++) begin
      q = int'($urandom_range(0, 65535));
      r = int'($urandom_range(0, 63));
      k = int'($urandom_range(0, 63));
      do_op(0, q, r, k, KP, int'($urandom_range(0, 3)));
      do_op(1, q, r, k, k, int'($urandom_range(0, 3)));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/constant_mul_seq.md
Name: constant_mul_seq

Overview:
- Sequential shift-add multiplier: the inverse of the team's reciprocal-multiply constant divider.
- Reconstructs a dividend from a quotient/remainder pair: o_res = i_quo * K + i_rem, where K is a parameter constant or a runtime input.
- Flags remainders that are out of range (i_rem >= K).
- Used as the checker/rebuilder on the far side of divide-by-constant paths; valid/ready handshake on both ends.

Parameters:
- MUL_MODE, 0, 0: K = MUL parameter; 1: K sampled from i_mul_const at accept
- MUL, 38, constant multiplier used when MUL_MODE=0
- QUO_W, 16, quotient width
- CONST_W, $clog2(MUL+1), width of K, i_mul_const and i_rem; also the number of BUSY iterations
- RES_W, QUO_W+CONST_W, result width; sized so overflow is impossible

Ports:
- i_clk  input  1  sole clock, rising edge
- i_rst  input  1  asynchronous, active-high reset
- i_vld  input  1  input pair valid
- o_rdy  output  1  block can accept a pair (high only in IDLE)
- i_quo  input  QUO_W  quotient operand
- i_rem  input  CONST_W  remainder operand
- i_mul_const  input  CONST_W  runtime K; ignored when MUL_MODE=0
- o_vld  output  1  result valid
- i_rdy  input  1  downstream accepts result
- o_res  output  RES_W  i_quo*K + i_rem
- o_rem_err  output  1  i_rem >= K (also set when K==0)

Behaviour:
- One clock, i_clk. Reset i_rst is asynchronous and active-high.
- Reset values: state=IDLE, o_vld=0, o_res=0, o_rem_err=0, internal regs=0. o_rdy=1 because it decodes state==IDLE.
- FSM states and transitions:
  - IDLE -> BUSY on i_vld & o_rdy (accept).
  - BUSY -> DONE after exactly CONST_W iterations.
  - DONE -> IDLE on o_vld & i_rdy.
- Accept, cycle T, registers load:
  - acc = zero-extended i_rem
  - mcand = zero-extended i_quo (RES_W bits)
  - mplier = K (MUL_MODE=0: MUL[CONST_W-1:0]; MUL_MODE=1: i_mul_const)
  - err = (i_rem >= K)
  - cnt = 0
- Each BUSY cycle:
  - if mplier[0], acc = acc + mcand (RES_W-bit add; no carry out is possible)
  - mcand <<= 1, mplier >>= 1, cnt++
  - on the cycle where cnt == CONST_W-1, next state = DONE
- No early exit on mplier==0. Latency is fixed and data-independent.
- DONE: o_vld=1, o_res=acc, o_rem_err=err.
  - o_res and o_rem_err are held stable while i_rdy=0, for any number of cycles.
- Timing:
  - accept at cycle T -> o_vld first high at T+CONST_W+1
  - handshake at cycle H -> o_rdy high at H+1, o_vld low at H+1
  - minimum initiation interval is CONST_W+2 cycles
- o_rdy=0 in BUSY and DONE. i_vld in those states is ignored and the inputs are not sampled. The upstream source must hold its pair.
- o_res and o_rem_err keep their last value after leaving DONE. Only o_vld qualifies them.
- MUL_MODE=1 with K==0: result = i_rem, o_rem_err=1.
- Any i_rem (0 .. 2^CONST_W-1) is computed exactly; an out-of-range remainder only sets the flag.
- Operands are not re-sampled after accept. Changing i_mul_const mid-operation has no effect.
- Reset asserted mid-BUSY or mid-DONE: the in-flight result is discarded, all outputs return to reset values immediately (async), and the block is in IDLE on the first edge after release.

Decomposition:
- Shared package const_arith_pkg:
  - typedef enum logic [1:0] {IDLE, BUSY, DONE} for the FSM
  - width helper function res_w(quo_w, const_w)
  - localparam CNT_W = $clog2(CONST_W)
  - the constant_div modules reuse the width helpers
- No sub-module. One add-shift datapath plus the FSM in a single module is the natural size (~150 RTL lines).

Test Plan:
- MUL_MODE=0, MUL=38, QUO_W=16; accept q=1000, r=37 at cycle 0, i_rdy=1 -> o_vld high at cycle 7 only, o_res=38037, o_rem_err=0, o_rdy high at cycle 8.
- q=65535, r=37 -> o_res=2490367 (max case, no overflow in 22 bits). Then q=0, r=0 -> o_res=0.
- q=10, r=38 -> o_res=418, o_rem_err=1. Then q=10, r=63 -> o_res=443, o_rem_err=1.
- Backpressure: hold i_rdy=0 for 5 cycles in DONE -> o_vld, o_res and o_rem_err stable, o_rdy=0. i_vld pulsed with other data during BUSY/DONE is not accepted, and the result is unchanged.
- MUL_MODE=1: K=0, q=5, r=3 -> o_res=3, o_rem_err=1. K=63, q=1023, r=62 -> o_res=64511, o_rem_err=0. Toggling i_mul_const during BUSY leaves the result unchanged.
- Assert i_rst two cycles after accept -> o_vld=0, o_res=0 and o_rdy=1 immediately. After release, a new pair q=7, r=1 (MUL=38) -> o_res=267 with full latency.
